// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RV32 datapath: sequences fetch/decode/execute/memory/writeback
// and traps on illegal opcodes or a memory request that never completes.
module multicycle_control #(
    parameter int CSR_EN      = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             alu_zero,
    input  logic             alu_last_bit,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             addr_source,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_source,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_control,
    output logic [2:0]       imm_source,
    output logic             reg_write,
    output logic             csr_write_enable,
    output logic [1:0]       write_back_source,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP = 3'd5
    } state_t;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_SYS = 7'b1110011;
    localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b0001, A_AND = 4'b0010, A_OR = 4'b0011,
                           A_SLT = 4'b0101, A_SLTU = 4'b0111, A_XOR = 4'b1000, A_BAD = 4'b1111;
    localparam int WW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              legal, br_taken;
    logic [3:0]        alu_dec, br_alu;

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_R, OP_I, OP_LD, OP_ST, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            OP_BR:  legal = (func3 != 3'b010) && (func3 != 3'b011);
            OP_SYS: legal = (CSR_EN != 0) && (func3 != 3'b000);
            default: legal = 1'b0;
        endcase
    end

    // Unsupported func3 (shifts) yields the invalid code but does not trap.
    always_comb begin
        alu_dec = A_BAD;
        case (func3)
            3'b000:  alu_dec = (op == OP_R && func7 == 7'b0100000) ? A_SUB : A_ADD;
            3'b111:  alu_dec = A_AND;
            3'b110:  alu_dec = A_OR;
            3'b100:  alu_dec = A_XOR;
            3'b010:  alu_dec = A_SLT;
            3'b011:  alu_dec = A_SLTU;
            default: alu_dec = A_BAD;
        endcase
    end

    always_comb begin
        br_alu   = A_BAD;
        br_taken = 1'b0;
        case (func3)
            3'b000: begin br_alu = A_SUB;  br_taken = alu_zero;      end
            3'b001: begin br_alu = A_SUB;  br_taken = !alu_zero;     end
            3'b100: begin br_alu = A_SLT;  br_taken = alu_last_bit;  end
            3'b101: begin br_alu = A_SLT;  br_taken = !alu_last_bit; end
            3'b110: begin br_alu = A_SLTU; br_taken = alu_last_bit;  end
            3'b111: begin br_alu = A_SLTU; br_taken = !alu_last_bit; end
            default: begin br_alu = A_BAD; br_taken = 1'b0;          end
        endcase
    end

    always_comb begin
        state_d           = state_q;
        wait_d            = '0;
        mem_req           = 1'b0;
        mem_write         = 1'b0;
        addr_source       = 1'b0;
        ir_write          = 1'b0;
        pc_write          = 1'b0;
        pc_source         = 1'b0;
        alu_src_a         = 2'b00;
        alu_src_b         = 2'b00;
        alu_control       = A_ADD;
        imm_source        = 3'b000;
        reg_write         = 1'b0;
        csr_write_enable  = 1'b0;
        write_back_source = 2'b00;
        trap              = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = S_DECODE;
                end else if (wait_q == WAIT_MAX) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                // Precompute the branch/jump target into the ALU output register.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_ST:            imm_source = 3'b001;
                    OP_BR:            imm_source = 3'b010;
                    OP_LUI, OP_AUIPC: imm_source = 3'b011;
                    OP_JAL:           imm_source = 3'b100;
                    default:          imm_source = 3'b000;
                endcase
                state_d = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                state_d = S_WB;
                case (op)
                    OP_R:  begin alu_src_a = 2'b10; alu_control = alu_dec; end
                    OP_I:  begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_control = alu_dec; end
                    OP_LD, OP_ST: begin
                        alu_src_a = 2'b10;
                        alu_src_b = 2'b01;
                        state_d   = S_MEM;
                    end
                    OP_BR: begin
                        alu_src_a   = 2'b10;
                        alu_control = br_alu;
                        pc_write    = br_taken;
                        pc_source   = br_taken;
                        state_d     = S_FETCH;
                    end
                    OP_JAL:   begin pc_write = 1'b1; pc_source = 1'b1; end
                    OP_JALR:  begin alu_src_a = 2'b10; alu_src_b = 2'b01; pc_write = 1'b1; end
                    OP_LUI:   begin alu_src_a = 2'b11; alu_src_b = 2'b01; end
                    OP_AUIPC: begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req     = 1'b1;
                addr_source = 1'b1;
                mem_write   = (op == OP_ST);
                if (mem_ready)                state_d = (op == OP_ST) ? S_FETCH : S_WB;
                else if (wait_q == WAIT_MAX)  state_d = S_TRAP;
                else                          wait_d  = wait_q + 1'b1;
            end
            S_WB: begin
                reg_write = 1'b1;
                case (op)
                    OP_LD:           write_back_source = 2'b01;
                    OP_JAL, OP_JALR: write_back_source = 2'b10;
                    OP_SYS: begin    write_back_source = 2'b11; csr_write_enable = 1'b1; end
                    default:         write_back_source = 2'b00;
                endcase
                state_d = S_FETCH;
            end
            S_TRAP:  trap = 1'b1;
            default: state_d = S_TRAP;
        endcase
    end

    always_comb begin
        instret_d = instret_q;
        if (state_d == S_FETCH &&
            (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
            instret_d = instret_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    assign state   = state_q;
    assign instret = instret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: default-parameter instance for the main flows,
// a second instance (CSR disabled, short timeout) for trap behaviour.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst, rst_t;
    logic [6:0] op, func7;
    logic [2:0] func3;
    logic alu_zero, alu_last_bit, mem_ready;

    logic mem_req, mem_write, addr_source, ir_write, pc_write, pc_source;
    logic [1:0] alu_src_a, alu_src_b, write_back_source;
    logic [3:0] alu_control;
    logic [2:0] imm_source, state;
    logic reg_write, csr_write_enable, trap;
    logic [31:0] instret;

    logic t_mem_req, t_mem_write, t_addr_source, t_ir_write, t_pc_write, t_pc_source;
    logic [1:0] t_alu_src_a, t_alu_src_b, t_wbs;
    logic [3:0] t_alu_control;
    logic [2:0] t_imm_source, t_state;
    logic t_reg_write, t_csr_we, t_trap;
    logic [7:0] t_instret;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .alu_zero(alu_zero), .alu_last_bit(alu_last_bit), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .addr_source(addr_source),
        .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .imm_source(imm_source), .reg_write(reg_write), .csr_write_enable(csr_write_enable),
        .write_back_source(write_back_source), .trap(trap), .state(state), .instret(instret)
    );

    multicycle_control #(.CSR_EN(0), .MEM_TIMEOUT(4), .CNT_W(8)) dut_t (
        .clk(clk), .rst(rst_t), .op(op), .func3(func3), .func7(func7),
        .alu_zero(alu_zero), .alu_last_bit(alu_last_bit), .mem_ready(mem_ready),
        .mem_req(t_mem_req), .mem_write(t_mem_write), .addr_source(t_addr_source),
        .ir_write(t_ir_write), .pc_write(t_pc_write), .pc_source(t_pc_source),
        .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b), .alu_control(t_alu_control),
        .imm_source(t_imm_source), .reg_write(t_reg_write), .csr_write_enable(t_csr_we),
        .write_back_source(t_wbs), .trap(t_trap), .state(t_state), .instret(t_instret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                          input logic rdy);
        op = o; func3 = f3; func7 = f7; mem_ready = rdy;
        #1;
    endtask

    initial begin
        rst = 1'b1; rst_t = 1'b1;
        op = '0; func3 = '0; func7 = '0;
        alu_zero = 1'b0; alu_last_bit = 1'b0; mem_ready = 1'b0;
        step();
        chk("rst_state", 32'(state), 0);
        chk("rst_instret", instret, 0);
        chk("rst_trap", 32'(trap), 0);
        chk("rst_memreq", 32'(mem_req), 1);
        rst = 1'b0;

        // ADD x3,x1,x2
        set_in(7'b0110011, 3'b000, 7'b0000000, 1'b1);
        chk("add_f_irw", 32'(ir_write), 1);
        chk("add_f_pcw", 32'(pc_write), 1);
        chk("add_f_srcb", 32'(alu_src_b), 2);
        step();
        chk("add_d_state", 32'(state), 1);
        chk("add_d_srca", 32'(alu_src_a), 1);
        chk("add_d_srcb", 32'(alu_src_b), 1);
        step();
        chk("add_e_state", 32'(state), 2);
        chk("add_e_alu", 32'(alu_control), 0);
        chk("add_e_rw", 32'(reg_write), 0);
        step();
        chk("add_wb_state", 32'(state), 4);
        chk("add_wb_rw", 32'(reg_write), 1);
        chk("add_wb_wbs", 32'(write_back_source), 0);
        step();
        chk("add_done_state", 32'(state), 0);
        chk("add_instret", instret, 1);

        // SUB
        set_in(7'b0110011, 3'b000, 7'b0100000, 1'b1);
        step(); step();
        chk("sub_e_alu", 32'(alu_control), 1);
        step(); step();
        chk("sub_instret", instret, 2);

        // BNE, not zero -> taken
        set_in(7'b1100011, 3'b001, 7'b0, 1'b1);
        alu_zero = 1'b0;
        step();
        chk("bne_d_imm", 32'(imm_source), 2);
        step();
        chk("bne_pcw", 32'(pc_write), 1);
        chk("bne_pcsrc", 32'(pc_source), 1);
        chk("bne_alu", 32'(alu_control), 1);
        step();
        chk("bne_state", 32'(state), 0);
        chk("bne_instret", instret, 3);

        // BGEU with last bit set -> not taken
        set_in(7'b1100011, 3'b111, 7'b0, 1'b1);
        alu_last_bit = 1'b1;
        step(); step();
        chk("bgeu_alu", 32'(alu_control), 7);
        chk("bgeu_pcw", 32'(pc_write), 0);
        step();
        chk("bgeu_instret", instret, 4);

        // LW with 4 wait cycles in MEM
        set_in(7'b0000011, 3'b010, 7'b0, 1'b1);
        step(); step();
        chk("lw_e_srca", 32'(alu_src_a), 2);
        chk("lw_e_srcb", 32'(alu_src_b), 1);
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("lw_mem_state", 32'(state), 3);
            chk("lw_mem_addr", 32'(addr_source), 1);
            step();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_mem_last", 32'(state), 3);
        chk("lw_mem_wr", 32'(mem_write), 0);
        step();
        chk("lw_wb_state", 32'(state), 4);
        chk("lw_wb_wbs", 32'(write_back_source), 1);
        step();
        chk("lw_instret", instret, 5);

        // SW
        set_in(7'b0100011, 3'b010, 7'b0, 1'b1);
        step();
        chk("sw_d_imm", 32'(imm_source), 1);
        step(); step();
        chk("sw_mem_state", 32'(state), 3);
        chk("sw_mem_wr", 32'(mem_write), 1);
        step();
        chk("sw_state", 32'(state), 0);
        chk("sw_instret", instret, 6);

        // CSR (enabled)
        set_in(7'b1110011, 3'b001, 7'b0, 1'b1);
        step(); step();
        chk("csr_e_state", 32'(state), 2);
        step();
        chk("csr_wb_we", 32'(csr_write_enable), 1);
        chk("csr_wb_wbs", 32'(write_back_source), 3);
        step();
        chk("csr_instret", instret, 7);

        // JAL
        set_in(7'b1101111, 3'b000, 7'b0, 1'b1);
        step();
        chk("jal_d_imm", 32'(imm_source), 4);
        step();
        chk("jal_pcw", 32'(pc_write), 1);
        chk("jal_pcsrc", 32'(pc_source), 1);
        step();
        chk("jal_wbs", 32'(write_back_source), 2);
        step();
        chk("jal_instret", instret, 8);

        // Illegal branch func3 -> TRAP, sticky
        set_in(7'b1100011, 3'b010, 7'b0, 1'b1);
        step();
        chk("ill_d_state", 32'(state), 1);
        step();
        chk("ill_state", 32'(state), 5);
        chk("ill_trap", 32'(trap), 1);
        chk("ill_memreq", 32'(mem_req), 0);
        step(); step();
        chk("ill_hold_state", 32'(state), 5);
        chk("ill_hold_instret", instret, 8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ill_rst_state", 32'(state), 0);
        chk("ill_rst_trap", 32'(trap), 0);
        chk("ill_rst_instret", instret, 0);

        // Reset while waiting in MEM
        set_in(7'b0000011, 3'b010, 7'b0, 1'b1);
        step(); step();
        mem_ready = 1'b0;
        step(); step();
        chk("mw_state", 32'(state), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mw_rst_state", 32'(state), 0);
        chk("mw_rst_instret", instret, 0);
        chk("mw_rst_memreq", 32'(mem_req), 1);

        // Fetch timeout with MEM_TIMEOUT=4
        rst = 1'b1;
        set_in(7'b0110011, 3'b000, 7'b0, 1'b0);
        step();
        rst_t = 1'b0;
        #1;
        chk("to_start", 32'(t_state), 0);
        step(); step(); step();
        chk("to_3cyc", 32'(t_state), 0);
        step();
        chk("to_state", 32'(t_state), 5);
        chk("to_trap", 32'(t_trap), 1);
        step(); step();
        chk("to_sticky", 32'(t_trap), 1);
        rst_t = 1'b1;
        step();
        rst_t = 1'b0;
        chk("to_rst_trap", 32'(t_trap), 0);

        // CSR opcode illegal when disabled
        set_in(7'b1110011, 3'b001, 7'b0, 1'b1);
        step();
        chk("nocsr_d_state", 32'(t_state), 1);
        step();
        chk("nocsr_trap_state", 32'(t_state), 5);
        chk("nocsr_instret", 32'(t_instret), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
